// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard detector and EX-operand forwarding selector.
// Tracks destination tags EX..WB, detects load-use and mult/div hazards, and registers forward selects.
module hazard_fwd_ctrl #(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 4,
    localparam int SW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rd,
    input  logic          id_regwr,
    input  logic          id_load,
    input  logic          id_md_start,
    input  logic          id_md_read,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] fwd_a,
    output logic [SW-1:0] fwd_b
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic          regwr;
        logic          load;
    } tag_t;

    tag_t          stage_reg [1:DEPTH];
    tag_t          stage_next;
    logic [7:0]    md_cnt_reg, md_cnt_next;
    logic [SW-1:0] fwd_a_reg, fwd_a_next;
    logic [SW-1:0] fwd_b_reg, fwd_b_next;

    logic                src_a_live, src_b_live;
    logic [DEPTH-1:1]    match_a, match_b;
    logic [LOAD_LAT:1]   lu_hit;
    logic                load_use, md_hazard, accept;

    // Register 0 is hard-wired, so a zero source never depends on anything.
    assign src_a_live = id_valid && (id_rs != '0);
    assign src_b_live = id_valid && (id_rt != '0);

    // Only stages 1..DEPTH-1 can forward; the last stage has already written through.
    generate
        for (genvar gi = 1; gi <= DEPTH - 1; gi++) begin : g_match
            logic producer;
            assign producer    = stage_reg[gi].valid && stage_reg[gi].regwr && (stage_reg[gi].rd != '0);
            assign match_a[gi] = producer && src_a_live && (stage_reg[gi].rd == id_rs);
            assign match_b[gi] = producer && src_b_live && (stage_reg[gi].rd == id_rt);
            if (gi <= LOAD_LAT) begin : g_lu
                assign lu_hit[gi] = stage_reg[gi].load && (match_a[gi] || match_b[gi]);
            end
        end
    endgenerate

    assign load_use  = |lu_hit;
    assign md_hazard = id_valid && (md_cnt_reg != 8'd0) && (id_md_read || id_md_start);
    assign stall     = (load_use || md_hazard) && !flush;
    assign accept    = id_valid && !stall && !flush;

    always_comb begin
        stage_next       = '0;
        stage_next.valid = accept;
        stage_next.rd    = id_rd;
        stage_next.regwr = id_regwr;
        stage_next.load  = id_load;

        // Scan oldest to youngest so the youngest match wins.
        fwd_a_next = '0;
        fwd_b_next = '0;
        for (int j = DEPTH - 1; j >= 1; j--) begin
            if (match_a[j]) fwd_a_next = SW'(j);
            if (match_b[j]) fwd_b_next = SW'(j);
        end
        if (!accept) begin
            fwd_a_next = '0;
            fwd_b_next = '0;
        end

        md_cnt_next = md_cnt_reg;
        if (accept && id_md_start) begin
            md_cnt_next = 8'(MD_LAT);
        end else if (md_cnt_reg != 8'd0) begin
            md_cnt_next = md_cnt_reg - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                stage_reg[k] <= '0;
            end
            md_cnt_reg <= '0;
            fwd_a_reg  <= '0;
            fwd_b_reg  <= '0;
        end else begin
            stage_reg[1] <= stage_next;
            for (int k = 2; k <= DEPTH; k++) begin
                stage_reg[k] <= stage_reg[k-1];
            end
            md_cnt_reg <= md_cnt_next;
            fwd_a_reg  <= fwd_a_next;
            fwd_b_reg  <= fwd_b_next;
        end
    end

    assign fwd_a = fwd_a_reg;
    assign fwd_b = fwd_b_reg;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding distances, load-use, mult/div busy, flush and reset.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_regwr, id_load, id_md_start, id_md_read, flush;
    logic       stall;
    logic [1:0] fwd_a, fwd_b;

    int checks = 0;
    int passed = 0;

    hazard_fwd_ctrl #(.AW(5), .DEPTH(3), .LOAD_LAT(1), .MD_LAT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_regwr    (id_regwr),
        .id_load     (id_load),
        .id_md_start (id_md_start),
        .id_md_read  (id_md_read),
        .flush       (flush),
        .stall       (stall),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) begin
            passed++;
            $display("check %-16s observed=%0d expected=%0d ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input int rs, input int rt, input int rd,
                          input logic wr, input logic ld, input logic ms, input logic mr,
                          input logic fl);
        id_valid    = v;
        id_rs       = 5'(rs);
        id_rt       = 5'(rt);
        id_rd       = 5'(rd);
        id_regwr    = wr;
        id_load     = ld;
        id_md_start = ms;
        id_md_read  = mr;
        flush       = fl;
        #1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_id(1, 5, 6, 5, 1, 1, 1, 1, 0);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_fwd_b", fwd_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU writes r5, then rs=r5 the next cycle.
        set_id(1, 1, 2, 5, 1, 0, 0, 0, 0);
        chk("rel_stall", stall, 0);
        step;
        chk("a_fwd_a", fwd_a, 0);
        set_id(1, 5, 0, 0, 0, 0, 0, 0, 0);
        chk("b_stall", stall, 0);
        step;
        chk("b_fwd_a", fwd_a, 1);
        chk("b_fwd_b", fwd_b, 0);
        // Reader two behind the writer.
        set_id(1, 0, 5, 0, 0, 0, 0, 0, 0);
        step;
        chk("c_fwd_b", fwd_b, 2);
        chk("c_fwd_a", fwd_a, 0);
        // Two writers of r5: youngest wins.
        set_id(1, 0, 0, 5, 1, 0, 0, 0, 0);
        step;
        set_id(1, 0, 0, 5, 1, 0, 0, 0, 0);
        step;
        set_id(1, 0, 5, 0, 0, 0, 0, 0, 0);
        step;
        chk("f_fwd_b_young", fwd_b, 1);
        // r9 at distance 2 forwards; at the last stage it does not.
        set_id(1, 0, 0, 9, 1, 0, 0, 0, 0);
        step;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step;
        set_id(1, 9, 0, 0, 0, 0, 0, 0, 0);
        step;
        chk("h_fwd_a_d2", fwd_a, 2);
        set_id(1, 9, 0, 0, 0, 0, 0, 0, 0);
        step;
        chk("j_fwd_a_wb", fwd_a, 0);

        // Load r7, immediate use: one stall, bubble, then forward from 2.
        set_id(1, 0, 0, 7, 1, 1, 0, 0, 0);
        step;
        set_id(1, 7, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_stall", stall, 1);
        step;
        chk("lu_bubble_fwd", fwd_a, 0);
        chk("lu_stall_rel", stall, 0);
        step;
        chk("lu_fwd_a", fwd_a, 2);

        // Flush during a load-use hazard.
        set_id(1, 0, 0, 7, 1, 1, 0, 0, 0);
        step;
        set_id(1, 7, 0, 0, 0, 0, 0, 0, 1);
        chk("fl_stall", stall, 0);
        step;
        chk("fl_bubble_fwd", fwd_a, 0);
        set_id(1, 0, 7, 0, 0, 0, 0, 0, 0);
        chk("fl_next_stall", stall, 0);
        step;
        chk("fl_next_fwd_b", fwd_b, 2);

        // r0 is never a dependency, even from a load.
        set_id(1, 0, 0, 0, 1, 1, 0, 0, 0);
        step;
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_stall", stall, 0);
        step;
        chk("r0_fwd_a", fwd_a, 0);

        // Mult/div start, then HI/LO read waits MD_LAT cycles.
        set_id(1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("md_start_stall", stall, 0);
        step;
        set_id(1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("md_stall_%0d", i), stall, 1);
            step;
        end
        chk("md_release", stall, 0);
        step;

        // Reset while busy with live tags.
        set_id(1, 0, 0, 6, 1, 0, 0, 0, 0);
        step;
        set_id(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step;
        set_id(1, 6, 0, 5, 1, 0, 0, 0, 0);
        step;
        chk("pre_rst_fwd_a", fwd_a, 2);
        set_id(1, 5, 5, 0, 0, 0, 0, 1, 0);
        chk("pre_rst_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_fwd_a", fwd_a, 0);
        chk("mid_rst_fwd_b", fwd_b, 0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_stall", stall, 0);
        step;
        chk("post_rst_fwd_a", fwd_a, 0);
        chk("post_rst_fwd_b", fwd_b, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have parameter AW, default 5: register-address width.
REQ-002 SHALL have parameter DEPTH, default 3: number of tracked stages after ID (EX..WB), legal range 2..8.
REQ-003 SHALL have parameter LOAD_LAT, default 1: number of stages, counted from EX, in which a load result is not yet forwardable; legal range 1..DEPTH-1.
REQ-004 SHALL have parameter MD_LAT, default 4: multiply/divide busy cycles, legal range 1..255.
REQ-005 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port id_valid, input, 1: ID stage holds a real instruction.
REQ-008 SHALL have ports id_rs and id_rt, input, AW each: ID source registers.
REQ-009 SHALL have port id_rd, input, AW: ID destination register.
REQ-010 SHALL have ports id_regwr and id_load, input, 1 each: ID writes the register file; ID is a load.
REQ-011 SHALL have ports id_md_start and id_md_read, input, 1 each: ID starts a mult/div; ID reads HI/LO.
REQ-012 SHALL have port flush, input, 1: squash the ID instruction.
REQ-013 SHALL have port stall, output, 1: freeze PC and IF/ID, inject bubble into EX.
REQ-014 SHALL have ports fwd_a and fwd_b, output, SW = clog2(DEPTH) each: EX operand select, 0 = register file, j = result of instruction j stages ahead.

Function
REQ-015 SHALL keep a tag pipeline stage[1..DEPTH]; each entry holds {valid, rd, regwr, load}.
REQ-016 SHALL advance each edge: stage[k+1] <= stage[k] for k = 1..DEPTH-1; stage[DEPTH] is discarded, because WB writes the register file with write-through.
REQ-017 SHALL load stage[1] with the ID fields when id_valid=1, stall=0 and flush=0; otherwise stage[1] SHALL become a bubble (valid=0).
REQ-018 SHALL treat a stage entry as a producer only when valid=1, regwr=1 and rd != 0.
REQ-019 SHALL compute each source match only when id_valid=1 and the source register != 0; register 0 SHALL never match.
REQ-020 SHALL drive the comb load-use hazard when any producer with load=1 in stage[1..LOAD_LAT] has rd equal to id_rs or id_rt.
REQ-021 SHALL keep an 8-bit md_cnt: loaded with MD_LAT on an accepted id_md_start, else decremented while nonzero; md_busy = (md_cnt != 0).
REQ-022 SHALL assert the comb md hazard when id_valid=1, md_busy=1 and either id_md_read=1 or id_md_start=1.
REQ-023 SHALL make stall = (load-use hazard OR md hazard) AND NOT flush; flush SHALL override stall.
REQ-024 SHALL register fwd_a/fwd_b at the edge, latency 1, valid while the instruction occupies EX.
REQ-025 SHALL load fwd_a with the smallest j in 1..DEPTH-1 such that the pre-edge stage[j] is a producer with rd == id_rs, else 0; fwd_b SHALL use id_rt the same way.
REQ-026 SHALL give the youngest producer (smallest j) priority when several stages match.
REQ-027 SHALL load fwd_a/fwd_b with 0 on any edge where stage[1] receives a bubble (stall, flush or id_valid=0).
REQ-028 SHALL accept id_md_start only when stage[1] receives the instruction; a stalled or flushed start SHALL NOT load md_cnt.
REQ-029 SHALL keep decrementing md_cnt during stall or flush.

Reset
REQ-030 SHALL, while rst_n=0, immediately clear all stage valid bits, md_cnt, fwd_a and fwd_b to 0.
REQ-031 SHALL hold stall at 0 while rst_n=0 and on the first edge after release, because no producers exist.
REQ-032 SHALL abandon in-flight tags and any mult/div busy count when reset asserts mid-operation.

Verification
REQ-033 SHALL pass: ALU write r5, next cycle ID reads rs=r5 -> fwd_a=1 in EX, stall=0.
REQ-034 SHALL pass: write r5, a non-writing instruction, then read rt=r5 -> fwd_b=2; with writes to r5 at j=1 and j=2, fwd_b=1.
REQ-035 SHALL pass: load r7 then immediate use rs=r7 (LOAD_LAT=1) -> stall=1 for exactly one cycle, then fwd_a=2, EX received one bubble.
REQ-036 SHALL pass: id_md_start accepted, then id_md_read on the next instruction -> stall=1 for MD_LAT cycles (4), released when md_cnt reaches 0.
REQ-037 SHALL pass: write r0, then read r0 -> fwd_a=0, and flush asserted during load-use -> stall=0 and bubble injected.
REQ-038 SHALL pass: rst_n pulled low with md_cnt=3 and valid tags -> stall=0, fwd_a=fwd_b=0, no forwarding from pre-reset tags.
